udma_l2_wr_arbiter: RTL

Round-robin arbiter sharing the uDMA write-only L2 port between N_REQ write requesters, such as the RX channel datapath, stream sinks and debug or trace writers. It has a single-entry output register that decouples requester handshakes from L2 backpressure. It sits between the requesters and the L2_wo_* interconnect port of udma_subsystem. It sustains one write per cycle while the L2 port grants continuously.

---
 rtl/udma_pkg.sv | 13 +
 rtl/udma_rr_sel.sv | 38 +++
 rtl/udma_l2_wr_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/udma_pkg.sv
// Shared uDMA definitions: default L2 data width and the L2 write request payload.
package udma_pkg;

    localparam int unsigned L2_DATA_WIDTH = 32;
    localparam int unsigned L2_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0]   addr;
        logic [L2_DATA_WIDTH-1:0]   wdata;
        logic [L2_DATA_WIDTH/8-1:0] be;
    } l2_wr_req_t;

endpackage

// File: rtl/udma_rr_sel.sv
// Round-robin winner selection starting at ptr, with optional strict priority for index 0.
// Shared between the L2 write and read port arbiters.
module udma_rr_sel #(
    parameter  int unsigned N_REQ    = 4,
    localparam int unsigned ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                prio_en,
    output logic [N_REQ-1:0]    winner,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);

    always_comb begin
        int unsigned pos;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        if (prio_en && req[0]) begin
            winner[0] = 1'b1;
            found     = 1'b1;
        end else begin
            // Wrap by subtraction so non-power-of-2 N_REQ rotates correctly.
            for (int unsigned k = 0; k < N_REQ; k++) begin
                pos = 32'(ptr) + k;
                if (pos >= N_REQ) pos = pos - N_REQ;
                if (!found && req[pos]) begin
                    found       = 1'b1;
                    winner[pos] = 1'b1;
                    idx         = ID_WIDTH'(pos);
                end
            end
        end
    end

endmodule

// File: rtl/udma_l2_wr_arbiter.sv
// Round-robin arbiter of N_REQ writers onto the uDMA write-only L2 port, one-entry output buffer.
// Define UDMA_L2_ARB_PRIO_EN to give requester 0 strict priority over the rotating rest.
module udma_l2_wr_arbiter
    import udma_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned DATA_WIDTH = L2_DATA_WIDTH,
    parameter  int unsigned ADDR_WIDTH = 32,
    localparam int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                                    sys_clk_i,
    input  logic                                    sys_rst_i,
    input  logic [N_REQ-1:0]                        req_i,
    output logic [N_REQ-1:0]                        gnt_o,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]        wdata_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]      be_i,
    output logic                                    L2_req_o,
    input  logic                                    L2_gnt_i,
    output logic [ADDR_WIDTH-1:0]                   L2_addr_o,
    output logic [DATA_WIDTH-1:0]                   L2_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                 L2_be_o,
    output logic [ID_WIDTH-1:0]                     owner_o,
    output logic                                    busy_o
);

`ifdef UDMA_L2_ARB_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    logic                    valid;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [ID_WIDTH-1:0]     owner_q;
    logic [ID_WIDTH-1:0]     rr_ptr;

    logic [N_REQ-1:0]        sel_onehot;
    logic [ID_WIDTH-1:0]     sel_idx;
    logic                    sel_found;
    logic                    can_accept;
    logic                    accept;
    logic [ID_WIDTH-1:0]     next_ptr;

    udma_rr_sel #(.N_REQ(N_REQ)) i_rr_sel (
        .req     (req_i),
        .ptr     (rr_ptr),
        .prio_en (PRIO_EN),
        .winner  (sel_onehot),
        .idx     (sel_idx),
        .found   (sel_found)
    );

    assign can_accept = !valid || L2_gnt_i;
    // Reset gates the combinational grant so no requester sees an accept while held in reset.
    assign accept     = can_accept && sel_found && !sys_rst_i;
    assign gnt_o      = accept ? sel_onehot : '0;
    assign next_ptr   = (sel_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            valid   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            valid   <= 1'b1;
            addr_q  <= addr_i[sel_idx];
            wdata_q <= wdata_i[sel_idx];
            be_q    <= be_i[sel_idx];
            owner_q <= sel_idx;
            if (!(PRIO_EN && sel_idx == '0)) rr_ptr <= next_ptr;
        end else if (L2_gnt_i) begin
            valid <= 1'b0;
        end
    end

    assign L2_req_o   = valid;
    assign busy_o     = valid;
    assign L2_addr_o  = addr_q;
    assign L2_wdata_o = wdata_q;
    assign L2_be_o    = be_q;
    assign owner_o    = owner_q;

endmodule
